// File: rtl/riscv_retire_checker_pkg.sv
// Shared types for the retire checker: FSM state encoding and fail codes.
package riscv_retire_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/riscv_retire_checker_if.sv
// Core-side observation bundle for the retire checker.
//   NUM_INST    retire counter of the core
//   OUTPUT_PORT core result port
//   HALT        core halt indication
// master: the core (drives), slave: the checker (samples).
interface riscv_retire_checker_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 32
);
  logic [CWIDTH-1:0] NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;

  modport master (output NUM_INST, output OUTPUT_PORT, output HALT);
  modport slave  (input  NUM_INST, input  OUTPUT_PORT, input  HALT);
endinterface

// File: rtl/riscv_retire_checker_entry.sv
// One answer-table entry: stores (num_inst, ans, mask), valid and passed,
// and flags when the current retire count hits this entry and whether the
// masked result agrees.
//   CLK/RST      clock, synchronous active-high reset (invalidates entry)
//   we           load entry and set valid
//   clr          clear passed (start of a run)
//   run          checker is in RUN; a hit with ok sets passed
//   cfg_*        entry contents to load
//   num_inst     core retire count, output_port core result
//   valid        entry loaded
//   match_c      valid, not yet passed, retire count equals entry count
//   ok_c         masked result equals masked answer
module riscv_retire_checker_entry #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic              clr,
  input  logic              run,
  input  logic [CWIDTH-1:0] cfg_num_inst,
  input  logic [DWIDTH-1:0] cfg_ans,
  input  logic [DWIDTH-1:0] cfg_mask,
  input  logic [CWIDTH-1:0] num_inst,
  input  logic [DWIDTH-1:0] output_port,
  output logic              valid,
  output logic              match_c,
  output logic              ok_c
);
  logic [CWIDTH-1:0] e_num_inst;
  logic [DWIDTH-1:0] e_ans;
  logic [DWIDTH-1:0] e_mask;
  logic              passed;

  // Entry storage and pass tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid      <= 1'b0;
      passed     <= 1'b0;
      e_num_inst <= '0;
      e_ans      <= '0;
      e_mask     <= '0;
    end else begin
      if (we) begin
        valid      <= 1'b1;
        e_num_inst <= cfg_num_inst;
        e_ans      <= cfg_ans;
        e_mask     <= cfg_mask;
      end
      if (clr) begin
        passed <= 1'b0;
      end else if (run && match_c && ok_c) begin
        passed <= 1'b1;
      end
    end
  end

  assign match_c = valid && !passed && (num_inst == e_num_inst);
  assign ok_c    = ((output_port ^ e_ans) & e_mask) == '0;

endmodule

// File: rtl/riscv_retire_checker.sv
// Retire checker: compares the core result port against a run-time loaded
// table of (retire count, answer, mask) entries and registers pass/fail
// status, the first failing entry and the RUN cycle count.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   CFG_WE/IDX/NUM_INST/ANS/MASK  table load (accepted only in IDLE)
//   ARM                       start or restart a run
//   core                      NUM_INST / OUTPUT_PORT / HALT (slave modport)
//   BUSY, DONE, FAIL, ALL_PASS  run status
//   FAIL_IDX, FAIL_GOT, FAIL_CODE  failure details
//   PASS_CNT, CYCLE_CNT        entries passed, saturating RUN cycle count
// Optional: define RETIRE_CHECKER_TIMEOUT_EN to add a watchdog that fails the
// run after TIMEOUT RUN cycles without a change of NUM_INST.
module riscv_retire_checker
  import riscv_retire_checker_pkg::*;
#(
  parameter  int unsigned NUM_TEST = 22,
  parameter  int unsigned DWIDTH   = 32,
  parameter  int unsigned CWIDTH   = 32,
  parameter  int unsigned TIMEOUT  = 4096,
  localparam int unsigned IDX_W    = $clog2(NUM_TEST)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [IDX_W-1:0]  CFG_IDX,
  input  logic [CWIDTH-1:0] CFG_NUM_INST,
  input  logic [DWIDTH-1:0] CFG_ANS,
  input  logic [DWIDTH-1:0] CFG_MASK,
  input  logic              ARM,
  riscv_retire_checker_if.slave core,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic              ALL_PASS,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_GOT,
  output logic [1:0]        FAIL_CODE,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [CWIDTH-1:0] CYCLE_CNT
);
  localparam int unsigned CNT_W = IDX_W + 1;

  state_e              state;
  logic                in_idle;
  logic                in_run;
  logic                start;
  logic [NUM_TEST-1:0] valid;
  logic [NUM_TEST-1:0] match_c;
  logic [NUM_TEST-1:0] ok_c;
  logic [NUM_TEST-1:0] miss_c;
  logic [CNT_W-1:0]    pass_inc_c;
  logic [CNT_W-1:0]    valid_cnt_c;
  logic [CNT_W-1:0]    pass_cnt_nxt_c;
  logic [IDX_W-1:0]    miss_idx_c;
  logic                timeout_c;

  assign in_idle = (state == ST_IDLE);
  assign in_run  = (state == ST_RUN);
  assign start   = ARM && !in_run;

  // Answer table.
  for (genvar g = 0; g < NUM_TEST; g++) begin : g_entry
    riscv_retire_checker_entry #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH)) u_entry (
      .CLK          (CLK),
      .RST          (RST),
      .we           (CFG_WE && in_idle && (CFG_IDX == IDX_W'(g))),
      .clr          (start),
      .run          (in_run),
      .cfg_num_inst (CFG_NUM_INST),
      .cfg_ans      (CFG_ANS),
      .cfg_mask     (CFG_MASK),
      .num_inst     (core.NUM_INST),
      .output_port  (core.OUTPUT_PORT),
      .valid        (valid[g]),
      .match_c      (match_c[g]),
      .ok_c         (ok_c[g])
    );
  end

  // Popcounts of this cycle's passes and of loaded entries; lowest-index miss.
  always_comb begin
    miss_c      = match_c & ~ok_c;
    pass_inc_c  = '0;
    valid_cnt_c = '0;
    miss_idx_c  = '0;
    for (int i = NUM_TEST - 1; i >= 0; i--) begin
      pass_inc_c  = pass_inc_c + CNT_W'(match_c[i] & ok_c[i]);
      valid_cnt_c = valid_cnt_c + CNT_W'(valid[i]);
      if (miss_c[i]) miss_idx_c = IDX_W'(i);
    end
    pass_cnt_nxt_c = PASS_CNT + pass_inc_c;
  end

`ifdef RETIRE_CHECKER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0]   wd_cnt;
  logic [CWIDTH-1:0] last_num_inst;

  // Watchdog: consecutive RUN cycles in which NUM_INST has not moved.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt        <= '0;
      last_num_inst <= '0;
    end else if (start) begin
      wd_cnt        <= '0;
      last_num_inst <= core.NUM_INST;
    end else if (in_run) begin
      last_num_inst <= core.NUM_INST;
      if (core.NUM_INST != last_num_inst) wd_cnt <= '0;
      else if (!timeout_c)                wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout_c = in_run && (core.NUM_INST == last_num_inst) &&
                     ((32'(wd_cnt) + 32'd1) >= TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT, FC_TIMEOUT};
  assign timeout_c      = 1'b0;
`endif

  // Run-control FSM with registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      ALL_PASS  <= 1'b0;
      FAIL_IDX  <= '0;
      FAIL_GOT  <= '0;
      FAIL_CODE <= FC_NONE;
      PASS_CNT  <= '0;
      CYCLE_CNT <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          PASS_CNT <= pass_cnt_nxt_c;
          if (CYCLE_CNT != '1) CYCLE_CNT <= CYCLE_CNT + CWIDTH'(1);
          if (|miss_c) begin
            state     <= ST_FAIL;
            BUSY      <= 1'b0;
            FAIL      <= 1'b1;
            FAIL_IDX  <= miss_idx_c;
            FAIL_GOT  <= core.OUTPUT_PORT;
            FAIL_CODE <= FC_MISMATCH;
          end else if (timeout_c) begin
            state     <= ST_FAIL;
            BUSY      <= 1'b0;
            FAIL      <= 1'b1;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= core.OUTPUT_PORT;
`ifdef RETIRE_CHECKER_TIMEOUT_EN
            FAIL_CODE <= FC_TIMEOUT;
`else
            FAIL_CODE <= FC_MISMATCH;
`endif
          end else if (core.HALT) begin
            state    <= ST_DONE;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            ALL_PASS <= (pass_cnt_nxt_c == valid_cnt_c);
          end
        end
        default: begin
          if (ARM) begin
            state     <= ST_RUN;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            ALL_PASS  <= 1'b0;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= '0;
            FAIL_CODE <= FC_NONE;
            PASS_CNT  <= '0;
            CYCLE_CNT <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_retire_checker.sv
// Bench for riscv_retire_checker: directed per-cycle vector table, a small
// instance for counter saturation and the optional watchdog, and randomized
// runs against a behavioural model of the answer table.
// Honours RETIRE_CHECKER_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_riscv_retire_checker;
  localparam int unsigned NT = 22;
  localparam logic [31:0] M  = 32'hffff_ffff;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Main instance signals
  logic        RST, CFG_WE, ARM;
  logic [4:0]  CFG_IDX;
  logic [31:0] CFG_NUM_INST, CFG_ANS, CFG_MASK;
  logic        BUSY, DONE, FAIL, ALL_PASS;
  logic [4:0]  FAIL_IDX;
  logic [31:0] FAIL_GOT;
  logic [1:0]  FAIL_CODE;
  logic [5:0]  PASS_CNT;
  logic [31:0] CYCLE_CNT;

  riscv_retire_checker_if #(.DWIDTH(32), .CWIDTH(32)) core_if ();

  riscv_retire_checker #(.NUM_TEST(NT), .DWIDTH(32), .CWIDTH(32), .TIMEOUT(4096)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_NUM_INST(CFG_NUM_INST),
    .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK), .ARM(ARM), .core(core_if),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .ALL_PASS(ALL_PASS), .FAIL_IDX(FAIL_IDX),
    .FAIL_GOT(FAIL_GOT), .FAIL_CODE(FAIL_CODE), .PASS_CNT(PASS_CNT), .CYCLE_CNT(CYCLE_CNT)
  );

  // Small instance: 4-bit counters, TIMEOUT=16
  logic       s_rst, s_we, s_arm;
  logic [1:0] s_idx;
  logic [3:0] s_cn;
  logic [7:0] s_ca, s_cm;
  logic       s_busy, s_done, s_fail, s_allp;
  logic [1:0] s_fidx;
  logic [7:0] s_fgot;
  logic [1:0] s_code;
  logic [2:0] s_pcnt;
  logic [3:0] s_ccnt;

  riscv_retire_checker_if #(.DWIDTH(8), .CWIDTH(4)) s_if ();

  riscv_retire_checker #(.NUM_TEST(4), .DWIDTH(8), .CWIDTH(4), .TIMEOUT(16)) dut_s (
    .CLK(CLK), .RST(s_rst), .CFG_WE(s_we), .CFG_IDX(s_idx), .CFG_NUM_INST(s_cn),
    .CFG_ANS(s_ca), .CFG_MASK(s_cm), .ARM(s_arm), .core(s_if),
    .BUSY(s_busy), .DONE(s_done), .FAIL(s_fail), .ALL_PASS(s_allp), .FAIL_IDX(s_fidx),
    .FAIL_GOT(s_fgot), .FAIL_CODE(s_code), .PASS_CNT(s_pcnt), .CYCLE_CNT(s_ccnt)
  );

  typedef struct {
    logic rst, we; logic [4:0] idx; logic [31:0] cn, ca, cm;
    logic arm; logic [31:0] ni, op; logic halt;
  } in_t;
  typedef struct {
    logic b, d, f, a; logic [4:0] fi; logic [31:0] fg; logic [1:0] fc;
    logic [5:0] pc; logic [31:0] cc;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] rst, we, idx, cn, ca, cm, arm, ni, op, halt,
                              b, d, f, a, fi, fg, fc, pc, cc);
    vec_t v;
    v.i.rst = rst[0]; v.i.we = we[0]; v.i.idx = idx[4:0]; v.i.cn = cn; v.i.ca = ca; v.i.cm = cm;
    v.i.arm = arm[0]; v.i.ni = ni; v.i.op = op; v.i.halt = halt[0];
    v.o.b = b[0]; v.o.d = d[0]; v.o.f = f[0]; v.o.a = a[0]; v.o.fi = fi[4:0]; v.o.fg = fg;
    v.o.fc = fc[1:0]; v.o.pc = pc[5:0]; v.o.cc = cc;
    return v;
  endfunction

  task automatic drive(input in_t x);
    RST = x.rst; CFG_WE = x.we; CFG_IDX = x.idx; CFG_NUM_INST = x.cn;
    CFG_ANS = x.ca; CFG_MASK = x.cm; ARM = x.arm;
    core_if.NUM_INST = x.ni; core_if.OUTPUT_PORT = x.op; core_if.HALT = x.halt;
  endtask

  task automatic cmp_out(input string tag, input out_t e);
    chk({tag, " BUSY"},      32'(BUSY),      32'(e.b));
    chk({tag, " DONE"},      32'(DONE),      32'(e.d));
    chk({tag, " FAILST"},    32'(FAIL),      32'(e.f));
    chk({tag, " ALL_PASS"},  32'(ALL_PASS),  32'(e.a));
    chk({tag, " FAIL_IDX"},  32'(FAIL_IDX),  32'(e.fi));
    chk({tag, " FAIL_GOT"},  FAIL_GOT,       e.fg);
    chk({tag, " FAIL_CODE"}, 32'(FAIL_CODE), 32'(e.fc));
    chk({tag, " PASS_CNT"},  32'(PASS_CNT),  32'(e.pc));
    chk({tag, " CYCLE_CNT"}, CYCLE_CNT,      e.cc);
  endtask

  // Behavioural model: table as arrays, run status as a named phase.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_FAIL} mst_e;
  mst_e        ms;
  bit          mv [NT];
  bit          mp [NT];
  logic [31:0] mn [NT];
  logic [31:0] ma [NT];
  logic [31:0] mm [NT];
  out_t        mo;

  task automatic model_step(input in_t x);
    int npass, nvalid, fidx;
    if (x.rst) begin
      ms = M_IDLE;
      for (int i = 0; i < NT; i++) begin mv[i] = 0; mp[i] = 0; end
      mo = '{default: '0};
      return;
    end
    if (ms == M_RUN) begin
      npass = 0; nvalid = 0; fidx = -1;
      for (int i = 0; i < NT; i++) begin
        if (mv[i]) nvalid++;
        if (mv[i] && !mp[i] && mn[i] == x.ni) begin
          if (((x.op ^ ma[i]) & mm[i]) == 32'd0) begin mp[i] = 1; npass++; end
          else if (fidx < 0) fidx = i;
        end
      end
      mo.pc = mo.pc + 6'(npass);
      if (mo.cc != M) mo.cc = mo.cc + 32'd1;
      if (fidx >= 0) begin
        ms = M_FAIL; mo.b = 0; mo.f = 1; mo.fi = 5'(fidx); mo.fg = x.op; mo.fc = 2'd1;
      end else if (x.halt) begin
        ms = M_DONE; mo.b = 0; mo.d = 1; mo.a = (int'(mo.pc) == nvalid);
      end
    end else begin
      if (ms == M_IDLE && x.we && x.idx < NT) begin
        mv[x.idx] = 1; mn[x.idx] = x.cn; ma[x.idx] = x.ca; mm[x.idx] = x.cm;
      end
      if (x.arm) begin
        ms = M_RUN;
        for (int i = 0; i < NT; i++) mp[i] = 0;
        mo = '{default: '0};
        mo.b = 1;
      end
    end
  endtask

  task automatic step_model(input in_t x, input string tag);
    drive(x);
    model_step(x);
    tick();
    cmp_out(tag, mo);
  endtask

  vec_t        vt[$];
  in_t         rx;
  logic [31:0] r_ni;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    RST = 1; CFG_WE = 0; CFG_IDX = 0; CFG_NUM_INST = 0; CFG_ANS = 0; CFG_MASK = 0; ARM = 0;
    core_if.NUM_INST = 0; core_if.OUTPUT_PORT = 0; core_if.HALT = 0;
    s_rst = 1; s_we = 0; s_idx = 0; s_cn = 0; s_ca = 0; s_cm = 0; s_arm = 0;
    s_if.NUM_INST = 0; s_if.OUTPUT_PORT = 8'h5a; s_if.HALT = 0;

    //          rst we idx cn  ca           cm     arm ni  op           halt | b d f a fi fg     fc pc cc
    vt.push_back(mk(1, 0, 0,  0, 0,           0,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 0,  1, 0,           M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 1,  2, 32'hcc,      M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 2,  4, 32'h2dd,     M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  1,  0,           0,   1,0,0,0,0, 0,     0, 1, 1));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  2,  32'hcc,      0,   1,0,0,0,0, 0,     0, 2, 2));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  3,  32'h55,      0,   1,0,0,0,0, 0,     0, 2, 3));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  4,  32'h2dd,     1,   0,1,0,1,0, 0,     0, 3, 4));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  5,  0,           0,   0,1,0,1,0, 0,     0, 3, 4));
    vt.push_back(mk(1, 0, 0,  0, 0,           0,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 5,  8, 32'hffffffcc, M,    0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  8,  32'hcc,      0,   0,0,1,0,5, 32'hcc,1, 0, 1));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  9,  0,           0,   0,0,1,0,5, 32'hcc,1, 0, 1));
    vt.push_back(mk(1, 0, 0,  0, 0,           0,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 1,  9, 32'hcc,      32'hff,0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 2, 10, 32'hcc,      32'hff,0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 3, 10, 32'h11,      M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 23,10, 32'h5,       M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  9,  32'habcd00cc,0,   1,0,0,0,0, 0,     0, 1, 1));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0, 10,  32'hcc,      0,   0,0,1,0,3, 32'hcc,1, 2, 2));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 3, 10, 32'hcc,      M,     0,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 1));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  9,  32'hcc,      0,   1,0,0,0,0, 0,     0, 1, 2));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0, 10,  32'hcc,      1,   0,0,1,0,3, 32'hcc,1, 2, 3));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  1,  0,           0,   1,0,0,0,0, 0,     0, 0, 1));
    vt.push_back(mk(1, 0, 0,  0, 0,           0,     0,  1,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  0,  0,           1,   0,1,0,1,0, 0,     0, 0, 1));
    vt.push_back(mk(1, 0, 0,  0, 0,           0,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 1, 0,  5, 1,           M,     0,  0,  0,           0,   0,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     1,  0,  0,           0,   1,0,0,0,0, 0,     0, 0, 0));
    vt.push_back(mk(0, 0, 0,  0, 0,           0,     0,  1,  0,           1,   0,1,0,0,0, 0,     0, 0, 1));

    // Directed vector table
    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].i);
      tick();
      cmp_out($sformatf("vec%0d", k), vt[k].o);
    end

    // Small instance: CYCLE_CNT saturation with NUM_INST moving every cycle
    tick();
    s_rst = 0; s_arm = 1; tick(); s_arm = 0;
    for (int c = 0; c < 20; c++) begin
      s_if.NUM_INST = s_if.NUM_INST + 4'd1;
      tick();
      if (c == 13) chk("sat_pre CYCLE_CNT", 32'(s_ccnt), 32'd14);
    end
    chk("sat CYCLE_CNT", 32'(s_ccnt), 32'd15);
    chk("sat BUSY", 32'(s_busy), 32'd1);
    s_if.HALT = 1; tick(); s_if.HALT = 0;
    chk("small_empty DONE", 32'(s_done), 32'd1);
    chk("small_empty ALL_PASS", 32'(s_allp), 32'd1);

    // Small instance: NUM_INST frozen after ARM
    s_arm = 1; tick(); s_arm = 0;
`ifdef RETIRE_CHECKER_TIMEOUT_EN
    for (int c = 0; c < 15; c++) tick();
    chk("wd_pre BUSY", 32'(s_busy), 32'd1);
    tick();
    chk("wd FAIL", 32'(s_fail), 32'd1);
    chk("wd FAIL_CODE", 32'(s_code), 32'd2);
    chk("wd FAIL_IDX", 32'(s_fidx), 32'd0);
    chk("wd FAIL_GOT", 32'(s_fgot), 32'h5a);
`else
    for (int c = 0; c < 40; c++) tick();
    chk("nowd BUSY", 32'(s_busy), 32'd1);
    chk("nowd FAIL_CODE", 32'(s_code), 32'd0);
`endif

    // Randomized runs against the model
    for (int ep = 0; ep < 40; ep++) begin
      rx = '{default: '0}; rx.rst = 1;
      step_model(rx, $sformatf("r%0d rst", ep));
      for (int k = 0; k < int'($urandom_range(0, 8)); k++) begin
        rx = '{default: '0};
        rx.we  = 1;
        rx.idx = 5'($urandom_range(0, 26));
        rx.cn  = $urandom_range(1, 12);
        case ($urandom_range(0, 2))
          0: rx.ca = 32'hcc;
          1: rx.ca = 32'h11;
          default: rx.ca = $urandom;
        endcase
        case ($urandom_range(0, 2))
          0: rx.cm = M;
          1: rx.cm = 32'hff;
          default: rx.cm = $urandom;
        endcase
        step_model(rx, $sformatf("r%0d ld%0d", ep, k));
      end
      rx = '{default: '0}; rx.arm = 1; r_ni = 0;
      step_model(rx, $sformatf("r%0d arm", ep));
      for (int c = 0; c < 30; c++) begin
        rx = '{default: '0};
        r_ni = r_ni + 32'($urandom_range(0, 1));
        rx.arm = ($urandom_range(0, 7) == 0);
        if (rx.arm && ms != M_RUN) r_ni = 0;
        rx.ni = r_ni;
        rx.op = $urandom;
        for (int j = 0; j < NT; j++)
          if (mv[j] && mn[j] == r_ni && $urandom_range(0, 3) != 0)
            rx.op = (ma[j] & mm[j]) | ($urandom & ~mm[j]);
        rx.halt = ($urandom_range(0, 11) == 0) || (r_ni > 13);
        if ($urandom_range(0, 4) == 0) begin
          rx.we = 1; rx.idx = 5'($urandom_range(0, 21));
          rx.cn = r_ni; rx.ca = $urandom; rx.cm = M;
        end
        rx.rst = ($urandom_range(0, 59) == 0);
        step_model(rx, $sformatf("r%0d c%0d", ep, c));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
